cdb_arbiter: RTL and testbench

Common-data-bus transmitter for the Tomasulo core. It collects completed results from the functional-unit reservation stations (ALU, MUL, DIV, LD), buffers them per source, and broadcasts one tag/data pair per cycle. The broadcast uses the 8-bit tag format `{FU type[7:5], rs number[4:0]}`. It drives the `cdb_rs_num`/`cdb_data` inputs of the register file/RAT and of every reservation station.

---
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus transmitter: per-source result FIFOs feeding one registered tag/data broadcast per cycle.
// Build option CDB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module cdb_arbiter #(
    parameter int N_SRC = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [N_SRC*8-1:0]   src_tag,
    input  logic [N_SRC*32-1:0]  src_data,
    output logic                 cdb_valid,
    output logic [7:0]           cdb_rs_num,
    output logic [31:0]          cdb_data,
    output logic [N_SRC-1:0]     cdb_grant,
    output logic [7:0]           busy_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int NW = $clog2(N_SRC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]       r_tag_mem  [N_SRC][DEPTH];
    logic [31:0]      r_data_mem [N_SRC][DEPTH];
    logic [PW-1:0]    r_wr_ptr   [N_SRC];
    logic [PW-1:0]    r_rd_ptr   [N_SRC];
    logic [CW-1:0]    r_count    [N_SRC];
    logic [N_SRC-1:0] r_ready;
    logic             r_cdb_valid;
    logic [7:0]       r_cdb_rs_num;
    logic [31:0]      r_cdb_data;
    logic [N_SRC-1:0] r_cdb_grant;
    logic [7:0]       r_busy_cnt;

    logic [N_SRC-1:0] w_accept;
    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_nonempty;
    logic [N_SRC-1:0] w_pop;
    logic [CW-1:0]    w_count_nxt [N_SRC];
    logic [SW-1:0]    w_scan;
    logic             w_take;
    logic [SW-1:0]    w_win_idx;
    logic             w_win_found;
    logic [NW-1:0]    w_ne_cnt;
    logic [7:0]       w_head_tag;
    logic [31:0]      w_head_data;

`ifdef CDB_ROUND_ROBIN_EN
    logic [SW-1:0]    r_rr;
`endif

    function automatic logic [N_SRC-1:0] onehot(input logic [SW-1:0] idx);
        logic [N_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Handshake decode; a tag-0 push is accepted but never stored because tag 0 means "no producer".
    always_comb begin
        w_accept   = src_valid & r_ready;
        w_push     = '0;
        w_nonempty = '0;
        w_ne_cnt   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_push[i]     = w_accept[i] && (src_tag[8*i +: 8] != 8'h00);
            w_nonempty[i] = (r_count[i] != '0);
            w_ne_cnt      = w_ne_cnt + NW'(w_nonempty[i]);
        end
    end

    // Winner selection over non-empty FIFOs and head-of-queue read.
    always_comb begin
        w_scan      = '0;
        w_take      = 1'b0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
            w_scan = SW'((int'(r_rr) + k) % N_SRC);
`else
            w_scan = SW'(k);
`endif
            w_take      = !w_win_found && w_nonempty[w_scan];
            w_win_idx   = w_take ? w_scan : w_win_idx;
            w_win_found = w_win_found || w_take;
        end
        w_pop       = w_win_found ? onehot(w_win_idx) : '0;
        w_head_tag  = r_tag_mem[w_win_idx][r_rd_ptr[w_win_idx]];
        w_head_data = r_data_mem[w_win_idx][r_rd_ptr[w_win_idx]];
    end

    // Occupancy update; a same-cycle push and pop leaves the count unchanged.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            case ({w_push[i], w_pop[i]})
                2'b10:   w_count_nxt[i] = r_count[i] + CW'(1);
                2'b01:   w_count_nxt[i] = r_count[i] - CW'(1);
                default: w_count_nxt[i] = r_count[i];
            endcase
        end
    end

    // Result storage; payload needs no reset since it is only read when the count says it is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wr_ptr[i]]  <= src_tag[8*i +: 8];
                r_data_mem[i][r_wr_ptr[i]] <= src_data[32*i +: 32];
            end
        end
    end

    // FIFO pointers, counts and the registered not-full ready flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_ready <= '1;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
                end
                r_count[i] <= w_count_nxt[i];
                r_ready[i] <= (w_count_nxt[i] != FULL_CNT);
            end
        end
    end

    // Broadcast register and contention counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rs_num <= 8'h00;
            r_cdb_data   <= 32'h0000_0000;
            r_cdb_grant  <= '0;
            r_busy_cnt   <= 8'h00;
        end else begin
            r_cdb_valid  <= w_win_found;
            r_cdb_rs_num <= w_win_found ? w_head_tag : 8'h00;
            r_cdb_data   <= w_win_found ? w_head_data : 32'h0000_0000;
            r_cdb_grant  <= w_pop;
            if ((w_ne_cnt > NW'(1)) && (r_busy_cnt != 8'hFF)) begin
                r_busy_cnt <= r_busy_cnt + 8'd1;
            end
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    // Rotating priority: the source after the last winner goes first next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_win_found) begin
            r_rr <= SW'((int'(w_win_idx) + 1) % N_SRC);
        end
    end
`endif

    assign src_ready  = r_ready;
    assign cdb_valid  = r_cdb_valid;
    assign cdb_rs_num = r_cdb_rs_num;
    assign cdb_data   = r_cdb_data;
    assign cdb_grant  = r_cdb_grant;
    assign busy_cnt   = r_busy_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-source expected-result queues checked against every broadcast.
module tb_cdb_arbiter;
    localparam int N_SRC = 4;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [31:0]  src_tag;
    logic [127:0] src_data;
    logic         cdb_valid;
    logic [7:0]   cdb_rs_num;
    logic [31:0]  cdb_data;
    logic [3:0]   cdb_grant;
    logic [7:0]   busy_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [39:0] q2[$];
    logic [39:0] q3[$];

    cdb_arbiter #(.N_SRC(N_SRC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_tag    (src_tag),
        .src_data   (src_data),
        .cdb_valid  (cdb_valid),
        .cdb_rs_num (cdb_rs_num),
        .cdb_data   (cdb_data),
        .cdb_grant  (cdb_grant),
        .busy_cnt   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input int s, input logic [7:0] t, input logic [31:0] d);
        case (s)
            0: q0.push_back({t, d});
            1: q1.push_back({t, d});
            2: q2.push_back({t, d});
            3: q3.push_back({t, d});
            default: ;
        endcase
    endtask

    function automatic int q_size(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return 0;
        endcase
    endfunction

    function automatic logic [39:0] pop_exp(input int s);
        logic [39:0] v;
        v = 40'h0;
        case (s)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            2: v = q2.pop_front();
            3: v = q3.pop_front();
            default: v = 40'h0;
        endcase
        return v;
    endfunction

    task automatic set_src(input int s, input logic v, input logic [7:0] t, input logic [31:0] d);
        src_valid[s]         = v;
        src_tag[8*s +: 8]    = t;
        src_data[32*s +: 32] = d;
    endtask

    // Every broadcast must match the oldest outstanding result of the granted source.
    always @(negedge clk) begin : mon
        logic [39:0] e;
        int s;
        int pend;
        if (!rst) begin
            if (cdb_valid) begin
                case (cdb_grant)
                    4'b0001: s = 0;
                    4'b0010: s = 1;
                    4'b0100: s = 2;
                    4'b1000: s = 3;
                    default: s = -1;
                endcase
                chk("grant_onehot", 64'(s >= 0), 64'(1'b1));
                pend = q_size(s);
                chk("bcast_expected", 64'(pend != 0), 64'(1'b1));
                if (pend != 0) begin
                    e = pop_exp(s);
                    chk("bcast_tag", 64'(cdb_rs_num), 64'(e[39:32]));
                    chk("bcast_data", 64'(cdb_data), 64'(e[31:0]));
                end
            end else begin
                chk("idle_zero", 64'({cdb_rs_num, cdb_data, cdb_grant}), 64'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int alu_i;
        int mul_i;
        logic alu_go;
        logic mul_go;
        logic [3:0] g;

        rst       = 1'b1;
        src_valid = 4'h0;
        src_tag   = 32'h0;
        src_data  = 128'h0;
        repeat (2) @(negedge clk);
        chk("rst_src_ready", 64'(src_ready), 64'h0F);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb_grant", 64'(cdb_grant), 64'h0);
        chk("rst_busy_cnt",  64'(busy_cnt),  64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single source, minimum latency.
        set_src(0, 1'b1, 8'h03, 32'hDEADBEEF);
        expect_push(0, 8'h03, 32'hDEADBEEF);
        @(posedge clk); #1;
        set_src(0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("single_not_yet", 64'(cdb_valid), 64'h0);
        @(negedge clk);
        chk("single_valid", 64'(cdb_valid),  64'h1);
        chk("single_tag",   64'(cdb_rs_num), 64'h03);
        chk("single_data",  64'(cdb_data),   64'hDEADBEEF);
        chk("single_grant", 64'(cdb_grant),  64'h1);
        @(negedge clk);
        chk("single_idle", 64'(cdb_valid), 64'h0);

        // Reset in the middle of a broadcast with two entries still queued.
        @(posedge clk); #1;
        set_src(0, 1'b1, 8'h01, 32'h0000_0A01);
        set_src(1, 1'b1, 8'h22, 32'h0000_0B22);
        set_src(2, 1'b1, 8'h43, 32'h0000_0C43);
        @(posedge clk); #1;
        src_valid = 4'h0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(cdb_valid), 64'h1);
        chk("pre_rst_grant", 64'(cdb_grant), 64'h1);
        rst = 1'b1;
        #1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        chk("async_rst_valid", 64'(cdb_valid),  64'h0);
        chk("async_rst_tag",   64'(cdb_rs_num), 64'h0);
        chk("async_rst_data",  64'(cdb_data),   64'h0);
        chk("async_rst_grant", 64'(cdb_grant),  64'h0);
        chk("async_rst_ready", 64'(src_ready),  64'h0F);
        chk("async_rst_busy",  64'(busy_cnt),   64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(cdb_valid), 64'h0);
        end

        // All four sources at once.
        @(posedge clk); #1;
        set_src(0, 1'b1, 8'h01, 32'h1111_1111);
        set_src(1, 1'b1, 8'h22, 32'h2222_2222);
        set_src(2, 1'b1, 8'h43, 32'h3333_3333);
        set_src(3, 1'b1, 8'h64, 32'h4444_4444);
        expect_push(0, 8'h01, 32'h1111_1111);
        expect_push(1, 8'h22, 32'h2222_2222);
        expect_push(2, 8'h43, 32'h3333_3333);
        expect_push(3, 8'h64, 32'h4444_4444);
        @(posedge clk); #1;
        src_valid = 4'h0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g = 4'b0001 << k;
            chk("contend_grant", 64'(cdb_grant), 64'(g));
        end
        chk("contend_busy", 64'(busy_cnt), 64'h3);
        @(negedge clk);
        chk("contend_idle", 64'(cdb_valid), 64'h0);
        chk("contend_busy_hold", 64'(busy_cnt), 64'h3);

        // Priority wrap: a lone MUL grant moves the pointer to DIV, then ALU and LD compete.
        @(posedge clk); #1;
        set_src(1, 1'b1, 8'h25, 32'h5555_0025);
        expect_push(1, 8'h25, 32'h5555_0025);
        @(posedge clk); #1;
        src_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_mul_grant", 64'(cdb_grant), 64'h2);
        @(posedge clk); #1;
        set_src(0, 1'b1, 8'h02, 32'h6666_0002);
        set_src(3, 1'b1, 8'h66, 32'h7777_0066);
        expect_push(0, 8'h02, 32'h6666_0002);
        expect_push(3, 8'h66, 32'h7777_0066);
        @(posedge clk); #1;
        src_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
`ifdef CDB_ROUND_ROBIN_EN
        chk("wrap_first",  64'(cdb_grant), 64'h8);
`else
        chk("wrap_first",  64'(cdb_grant), 64'h1);
`endif
        @(negedge clk);
`ifdef CDB_ROUND_ROBIN_EN
        chk("wrap_second", 64'(cdb_grant), 64'h1);
`else
        chk("wrap_second", 64'(cdb_grant), 64'h8);
`endif
        @(negedge clk);
        chk("wrap_busy", 64'(busy_cnt), 64'h4);

        // Backpressure: ALU floods every cycle while MUL holds its request.
        @(posedge clk); #1;
        alu_i = 0;
        mul_i = 0;
        set_src(0, 1'b1, 8'h10, 32'hA000_0000);
        set_src(1, 1'b1, 8'h30, 32'hB000_0000);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            alu_go = src_valid[0] && src_ready[0];
            mul_go = src_valid[1] && src_ready[1];
`ifndef CDB_ROUND_ROBIN_EN
            if (c == 2) chk("mul_full_ready", 64'(src_ready[1]), 64'h0);
            if (c == 6) chk("mul_still_full", 64'(src_ready[1]), 64'h0);
`endif
            @(posedge clk); #1;
            if (alu_go) begin
                expect_push(0, 8'(8'h10 + alu_i), 32'(32'hA000_0000 + alu_i));
                alu_i++;
                if (alu_i < 6) set_src(0, 1'b1, 8'(8'h10 + alu_i), 32'(32'hA000_0000 + alu_i));
                else           set_src(0, 1'b0, 8'h00, 32'h0);
            end
            if (mul_go) begin
                expect_push(1, 8'(8'h30 + mul_i), 32'(32'hB000_0000 + mul_i));
                mul_i++;
                if (mul_i < 4) set_src(1, 1'b1, 8'(8'h30 + mul_i), 32'(32'hB000_0000 + mul_i));
                else           set_src(1, 1'b0, 8'h00, 32'h0);
            end
        end
        @(negedge clk);
        chk("bp_alu_count", 64'(alu_i), 64'h6);
        chk("bp_mul_count", 64'(mul_i), 64'h4);
        chk("bp_ready_back", 64'(src_ready), 64'h0F);
        for (int s = 0; s < 4; s++) chk("bp_drained", 64'(q_size(s)), 64'h0);

        // Tag 0 on DIV: accepted every cycle, never stored or broadcast.
        @(posedge clk); #1;
        set_src(2, 1'b1, 8'h00, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("tag0_ready", 64'(src_ready[2]), 64'h1);
            chk("tag0_idle",  64'(cdb_valid),    64'h0);
        end
        @(posedge clk); #1;
        set_src(2, 1'b0, 8'h00, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("tag0_never", 64'(cdb_valid), 64'h0);
        end
        for (int s = 0; s < 4; s++) chk("final_drained", 64'(q_size(s)), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
